// File: rtl/nor8_zero_flag_pkg.sv
// Shared constants for the 8-input NOR zero detector.
//   CNT_W_DEFAULT   : default width of the zero-cycle counter
//   CNT_SAT_DEFAULT : all-ones saturation value for the default width
//   cnt_sat()       : all-ones saturation value for any counter width
package nor8_zero_flag_pkg;

    localparam int CNT_W_DEFAULT = 8;

    localparam logic [CNT_W_DEFAULT-1:0] CNT_SAT_DEFAULT = '1;

    function automatic logic [31:0] cnt_sat(input int width);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < width && i < 32; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/nor8_zero_flag_nor_tree.sv
// Combinational 8-input NOR core, usable by the ALU without the registers.
//   bits : eight bits under test
//   zero : 1 only when every bit is 0
module nor8_zero_flag_nor_tree (
    input  logic [7:0] bits,
    output logic       zero
);

    assign zero = ~|bits;

endmodule

// File: rtl/nor8_zero_flag.sv
// Zero detector for the ALU result with registered flag, rising-edge pulse
// and a saturating count of clock edges on which the result was zero.
//   CLK        : system clock, rising edge
//   RESET      : synchronous active-high reset
//   IN0..IN7   : bits under test (RESULT[0]..RESULT[7])
//   ZERO       : combinational NOR of IN0..IN7
//   ZERO_REG   : ZERO registered on CLK
//   ZERO_RISE  : ZERO & ~ZERO_REG, held low during reset
//   ZERO_COUNT : saturating count of edges with ZERO = 1
module nor8_zero_flag
    import nor8_zero_flag_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN0,
    input  logic             IN1,
    input  logic             IN2,
    input  logic             IN3,
    input  logic             IN4,
    input  logic             IN5,
    input  logic             IN6,
    input  logic             IN7,
    output logic             ZERO,
    output logic             ZERO_REG,
    output logic             ZERO_RISE,
    output logic [CNT_W-1:0] ZERO_COUNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0] in_bits;
    logic       zero_comb;
    logic       zero_q;
    logic [CNT_W-1:0] count_q;

    assign in_bits = {IN7, IN6, IN5, IN4, IN3, IN2, IN1, IN0};

    nor8_zero_flag_nor_tree u_nor_tree (
        .bits (in_bits),
        .zero (zero_comb)
    );

    // zero_q doubles as the previous-flag register used for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            zero_q  <= 1'b0;
            count_q <= '0;
        end else begin
            zero_q <= zero_comb;
            if (zero_comb && (count_q != CNT_MAX)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign ZERO       = zero_comb;
    assign ZERO_REG   = zero_q;
    assign ZERO_RISE  = zero_comb & ~zero_q & ~RESET;
    assign ZERO_COUNT = count_q;

endmodule

// File: tb/tb_nor8_zero_flag.sv
module tb_nor8_zero_flag;

    logic       CLK;
    logic       RESET;
    logic [7:0] in_v;
    logic       ZERO;
    logic       ZERO_REG;
    logic       ZERO_RISE;
    logic [7:0] ZERO_COUNT;

    int errors = 0;
    int checks = 0;

    // reference model state, updated at every rising edge from the values
    // that were applied during the cycle
    logic [7:0]  cur_v;
    logic        cur_rst;
    logic        m_reg;
    logic [31:0] m_cnt;
    logic        m_valid;

    nor8_zero_flag #(.CNT_W(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN0        (in_v[0]),
        .IN1        (in_v[1]),
        .IN2        (in_v[2]),
        .IN3        (in_v[3]),
        .IN4        (in_v[4]),
        .IN5        (in_v[5]),
        .IN6        (in_v[6]),
        .IN7        (in_v[7]),
        .ZERO       (ZERO),
        .ZERO_REG   (ZERO_REG),
        .ZERO_RISE  (ZERO_RISE),
        .ZERO_COUNT (ZERO_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic exp_zero(input logic [7:0] v);
        return (v == 8'd0);
    endfunction

    function automatic logic exp_rise();
        return exp_zero(cur_v) && !m_reg && !cur_rst;
    endfunction

    task automatic apply(input logic [7:0] v, input logic rst);
        cur_v   = v;
        cur_rst = rst;
        in_v    = v;
        RESET   = rst;
    endtask

    // advance past one rising edge and update the model
    task automatic tick();
        @(posedge CLK);
        if (cur_rst) begin
            m_reg   = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b1;
        end else begin
            if (exp_zero(cur_v)) m_cnt = (m_cnt >= 255) ? 32'd255 : m_cnt + 1;
            m_reg = exp_zero(cur_v);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(8'h00, 1'b1);
            tick();
            @(negedge CLK);
            checks++;
            if (ZERO !== 1'b1) begin
                errors++; $display("FAIL reset_zero cyc=%0d got=%b exp=1", i, ZERO);
            end
            checks++;
            if (ZERO_REG !== 1'b0) begin
                errors++; $display("FAIL reset_zero_reg cyc=%0d got=%b exp=0", i, ZERO_REG);
            end
            checks++;
            if (ZERO_COUNT !== 8'd0) begin
                errors++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, ZERO_COUNT);
            end
            checks++;
            if (ZERO_RISE !== 1'b0) begin
                errors++; $display("FAIL reset_rise cyc=%0d got=%b exp=0", i, ZERO_RISE);
            end
        end
    endtask

    // reset held throughout so the registered state stays cleared
    task automatic test_comb_sweep();
        for (int i = 0; i < 256; i++) begin
            apply(8'(i), 1'b1);
            #1;
            checks++;
            if (ZERO !== (i == 0)) begin
                errors++; $display("FAIL sweep_zero in=%02h got=%b exp=%b", i[7:0], ZERO, (i == 0));
            end
            checks++;
            if (ZERO_RISE !== 1'b0) begin
                errors++; $display("FAIL sweep_rise_in_reset in=%02h got=%b exp=0", i[7:0], ZERO_RISE);
            end
        end
        apply(8'h00, 1'b1);
        tick();
    endtask

    task automatic test_pulse();
        logic [7:0] seq [5]   = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h10};
        logic       e_rise[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       e_reg [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            apply(seq[i], 1'b0);
            @(negedge CLK);
            checks++;
            if (ZERO_RISE !== e_rise[i]) begin
                errors++; $display("FAIL pulse_rise step=%0d got=%b exp=%b", i, ZERO_RISE, e_rise[i]);
            end
            checks++;
            if (ZERO_REG !== e_reg[i]) begin
                errors++; $display("FAIL pulse_zero_reg step=%0d got=%b exp=%b", i, ZERO_REG, e_reg[i]);
            end
            tick();
        end
        @(negedge CLK);
        checks++;
        if (ZERO_REG !== 1'b0) begin
            errors++; $display("FAIL pulse_zero_reg_final got=%b exp=0", ZERO_REG);
        end
        checks++;
        if (ZERO_COUNT !== 8'd3) begin
            errors++; $display("FAIL pulse_count got=%0d exp=3", ZERO_COUNT);
        end
    endtask

    task automatic test_saturation();
        apply(8'h00, 1'b1);
        tick();
        for (int i = 0; i < 300; i++) begin
            apply(8'h00, 1'b0);
            tick();
            checks++;
            if ({24'd0, ZERO_COUNT} !== m_cnt) begin
                errors++; $display("FAIL sat_count edge=%0d got=%0d exp=%0d", i + 1, ZERO_COUNT, m_cnt);
            end
        end
        checks++;
        if (ZERO_COUNT !== 8'hFF) begin
            errors++; $display("FAIL sat_final got=%02h exp=ff", ZERO_COUNT);
        end
    endtask

    task automatic test_reset_mid();
        apply(8'h00, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(8'h00, 1'b0);
            tick();
        end
        checks++;
        if (ZERO_COUNT !== 8'd5) begin
            errors++; $display("FAIL mid_count_before got=%0d exp=5", ZERO_COUNT);
        end
        apply(8'h00, 1'b1);
        @(negedge CLK);
        checks++;
        if (ZERO_RISE !== 1'b0) begin
            errors++; $display("FAIL mid_rise_during_reset got=%b exp=0", ZERO_RISE);
        end
        tick();
        apply(8'h00, 1'b0);
        @(negedge CLK);
        checks++;
        if (ZERO_COUNT !== 8'd0 || ZERO_REG !== 1'b0) begin
            errors++; $display("FAIL mid_cleared count=%0d reg=%b exp count=0 reg=0", ZERO_COUNT, ZERO_REG);
        end
        checks++;
        if (ZERO_RISE !== 1'b1) begin
            errors++; $display("FAIL mid_rise_after_release got=%b exp=1", ZERO_RISE);
        end
        tick();
        checks++;
        if (ZERO_COUNT !== 8'd1) begin
            errors++; $display("FAIL mid_count_after got=%0d exp=1", ZERO_COUNT);
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic       r;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            r = ($urandom_range(0, 15) == 0);
            apply(v, r);
            @(negedge CLK);
            checks++;
            if (ZERO !== exp_zero(v)) begin
                errors++; $display("FAIL rand_zero i=%0d in=%02h got=%b exp=%b", i, v, ZERO, exp_zero(v));
            end
            checks++;
            if (ZERO_RISE !== exp_rise()) begin
                errors++; $display("FAIL rand_rise i=%0d in=%02h got=%b exp=%b", i, v, ZERO_RISE, exp_rise());
            end
            checks++;
            if (ZERO_REG !== m_reg) begin
                errors++; $display("FAIL rand_zero_reg i=%0d got=%b exp=%b", i, ZERO_REG, m_reg);
            end
            checks++;
            if ({24'd0, ZERO_COUNT} !== m_cnt) begin
                errors++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, ZERO_COUNT, m_cnt);
            end
            // glitch between edges: only the combinational outputs may react
            if (!r && $urandom_range(0, 3) == 0) begin
                in_v = ~v;
                #1;
                checks++;
                if (ZERO !== exp_zero(~v) || ZERO_REG !== m_reg) begin
                    errors++; $display("FAIL rand_midcycle i=%0d zero=%b reg=%b exp zero=%b reg=%b",
                                       i, ZERO, ZERO_REG, exp_zero(~v), m_reg);
                end
                in_v = v;
            end
            tick();
        end
    endtask

    task automatic test_alu();
        logic [7:0] a [3]  = '{8'h05, 8'hF0, 8'hF0};
        logic [7:0] b [3]  = '{8'hFB, 8'h0F, 8'h0F};
        logic       ez[3]  = '{1'b1, 1'b1, 1'b0};
        logic [7:0] res;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       res = a[i] + b[i];
                1:       res = a[i] & b[i];
                default: res = a[i] | b[i];
            endcase
            apply(res, 1'b0);
            #1;
            checks++;
            if (ZERO !== ez[i]) begin
                errors++; $display("FAIL alu_zero op=%0d result=%02h got=%b exp=%b", i, res, ZERO, ez[i]);
            end
            tick();
        end
    endtask

    initial begin
        m_reg   = 1'b0;
        m_cnt   = 0;
        m_valid = 1'b0;
        apply(8'h00, 1'b1);
        #1;
        test_reset();
        test_comb_sweep();
        test_pulse();
        test_saturation();
        test_reset_mid();
        apply(8'h00, 1'b1);
        tick();
        test_random();
        test_alu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
